sprite_pixel_fetch: RTL and testbench

- Per-pixel sprite compositor directly upstream of the colour mapper; produces the 4-bit palette index `sprite_data` for the current DrawX/DrawY.
- Holds per-sprite screen positions, shadowed once per frame. Drives one synchronous sprite-ROM port per sprite.
- Resolves priority and transparency between overlapping sprites. Reports a per-frame player-overlap (collision) flag to game logic.

---
 rtl/sprite_pixel_fetch.sv | 154 +++++++++++++++
 tb/tb_sprite_pixel_fetch.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_pixel_fetch.sv
// Per-pixel sprite compositor: frame-shadowed positions, 3-stage ROM fetch, priority and
// player-collision flag. Define SPRITE_FLIP_EN to build per-sprite horizontal mirroring.
module sprite_pixel_fetch #(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int ADDR_W      = 10
) (
  input  logic                          VGA_CLK,
  input  logic                          Reset_n,
  input  logic                          VGA_VS,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  input  logic [NUM_SPRITES*10-1:0]     spr_x,
  input  logic [NUM_SPRITES*10-1:0]     spr_y,
  input  logic [NUM_SPRITES-1:0]        spr_en,
  input  logic [NUM_SPRITES-1:0]        spr_flip,
  output logic [NUM_SPRITES*ADDR_W-1:0] rom_addr,
  input  logic [NUM_SPRITES*4-1:0]      rom_data,
  output logic [3:0]                    sprite_data,
  output logic                          collide
);

  localparam int XB = $clog2(SPR_W);
  localparam int YB = $clog2(SPR_H);
  localparam logic [10:0] W_LIM = 11'(SPR_W);
  localparam logic [10:0] H_LIM = 11'(SPR_H);

  logic                   vs_q;
  logic                   fs;
  logic [9:0]             sh_x [NUM_SPRITES];
  logic [9:0]             sh_y [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] sh_en;
`ifdef SPRITE_FLIP_EN
  localparam logic [XB-1:0] X_MAX = XB'(SPR_W - 1);
  logic [NUM_SPRITES-1:0] sh_flip;
`else
  logic unused_flip;
  assign unused_flip = ^spr_flip;
`endif

  logic [10:0]            x11, y11;
  logic                   on_screen;
  logic [10:0]            dx_c [NUM_SPRITES];
  logic [10:0]            dy_c [NUM_SPRITES];
  logic [XB-1:0]          xa_c [NUM_SPRITES];
  logic [ADDR_W-1:0]      addr_c [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] hit_c;
  logic [NUM_SPRITES-1:0] hit1, hit2;

  logic [3:0]             pix [NUM_SPRITES];
  logic [3:0]             sel;
  logic                   others;
  logic                   ovl;
  logic                   acc;

  // Frame start is the falling edge of VS; positions are latched only then so a
  // mid-frame move by game logic never tears the image.
  assign fs = vs_q & ~VGA_VS;

  always_ff @(posedge VGA_CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_q  <= 1'b1;
      sh_en <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sh_x[i] <= '0;
        sh_y[i] <= '0;
      end
`ifdef SPRITE_FLIP_EN
      sh_flip <= '0;
`endif
    end else begin
      vs_q <= VGA_VS;
      if (fs) begin
        sh_en <= spr_en;
        for (int i = 0; i < NUM_SPRITES; i++) begin
          sh_x[i] <= spr_x[i*10 +: 10];
          sh_y[i] <= spr_y[i*10 +: 10];
        end
`ifdef SPRITE_FLIP_EN
        sh_flip <= spr_flip;
`endif
      end
    end
  end

  assign x11       = {1'b0, DrawX};
  assign y11       = {1'b0, DrawY};
  assign on_screen = (DrawX < 10'd640) && (DrawY < 10'd480);

  // 11-bit offsets plus the explicit >= tests keep sprites near the right edge from
  // wrapping around to X = 0.
  always_comb begin
    hit_c = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      dx_c[i]  = x11 - {1'b0, sh_x[i]};
      dy_c[i]  = y11 - {1'b0, sh_y[i]};
      hit_c[i] = sh_en[i] && on_screen &&
                 (x11 >= {1'b0, sh_x[i]}) && (dx_c[i] < W_LIM) &&
                 (y11 >= {1'b0, sh_y[i]}) && (dy_c[i] < H_LIM);
      xa_c[i]  = dx_c[i][XB-1:0];
`ifdef SPRITE_FLIP_EN
      if (sh_flip[i]) xa_c[i] = X_MAX - dx_c[i][XB-1:0];
`endif
      addr_c[i] = hit_c[i] ? {dy_c[i][YB-1:0], xa_c[i]} : '0;
    end
  end

  always_ff @(posedge VGA_CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      hit1     <= '0;
      hit2     <= '0;
      rom_addr <= '0;
    end else begin
      hit1 <= hit_c;
      hit2 <= hit1;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        rom_addr[i*ADDR_W +: ADDR_W] <= addr_c[i];
      end
    end
  end

  // Scanning from lowest priority upward lets sprite 0 overwrite; ROM index 0 is
  // transparent so it never claims the pixel.
  always_comb begin
    sel    = 4'd0;
    others = 1'b0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      pix[i] = hit2[i] ? rom_data[i*4 +: 4] : 4'd0;
      if (pix[i] != 4'd0) sel = pix[i];
      if ((i > 0) && (pix[i] != 4'd0)) others = 1'b1;
    end
  end

  assign ovl = (pix[0] != 4'd0) && others;

  // An overlap landing on the fs cycle still belongs to the frame being reported.
  always_ff @(posedge VGA_CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      sprite_data <= 4'd0;
      acc         <= 1'b0;
      collide     <= 1'b0;
    end else begin
      sprite_data <= sel;
      if (fs) begin
        collide <= acc | ovl;
        acc     <= 1'b0;
      end else begin
        acc <= acc | ovl;
      end
    end
  end

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Randomized bench for sprite_pixel_fetch: a pixel-level reference model (plain integer
// geometry plus a fixed 3-cycle delay) is compared against the DUT every clock.
module tb_sprite_pixel_fetch;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int AW = 10;

  logic            VGA_CLK = 1'b0;
  logic            Reset_n = 1'b1;
  logic            VGA_VS;
  logic [9:0]      DrawX, DrawY;
  logic [N*10-1:0] spr_x, spr_y;
  logic [N-1:0]    spr_en, spr_flip;
  logic [N*AW-1:0] rom_addr;
  logic [N*4-1:0]  rom_data;
  logic [3:0]      sprite_data;
  logic            collide;

  logic [3:0]      mem [N][W*H];

  int              m_sx [N];
  int              m_sy [N];
  logic [N-1:0]    m_en;
`ifdef SPRITE_FLIP_EN
  logic [N-1:0]    m_flip;
`endif
  logic            m_prev_vs, m_acc, m_col;
  int              m_sd;
  logic [N*AW-1:0] m_addr;
  int              pipe_val [$];
  logic            pipe_ovl [$];

  int              tests = 0;
  int              failures = 0;
  int              clip_hits;

  sprite_pixel_fetch #(.NUM_SPRITES(N), .SPR_W(W), .SPR_H(H), .ADDR_W(AW)) dut (
    .VGA_CLK     (VGA_CLK),
    .Reset_n     (Reset_n),
    .VGA_VS      (VGA_VS),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .spr_x       (spr_x),
    .spr_y       (spr_y),
    .spr_en      (spr_en),
    .spr_flip    (spr_flip),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .sprite_data (sprite_data),
    .collide     (collide)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  // Synchronous sprite ROMs: data follows the address by one clock.
  always @(posedge VGA_CLK) begin
    for (int i = 0; i < N; i++) rom_data[i*4 +: 4] <= mem[i][rom_addr[i*AW +: AW]];
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void lookup(input int i, input int x, input int y,
                                 output int pix, output int addr);
    int dx, dy;
    pix  = 0;
    addr = 0;
    dx   = x - m_sx[i];
    dy   = y - m_sy[i];
    if (!m_en[i] || x >= 640 || y >= 480) return;
    if (dx < 0 || dx >= W || dy < 0 || dy >= H) return;
`ifdef SPRITE_FLIP_EN
    if (m_flip[i]) dx = W - 1 - dx;
`endif
    addr = dy * W + dx;
    pix  = int'(mem[i][addr]);
  endfunction

  task automatic modelReset();
    m_prev_vs = 1'b1;
    m_acc     = 1'b0;
    m_col     = 1'b0;
    m_sd      = 0;
    m_addr    = '0;
    m_en      = '0;
`ifdef SPRITE_FLIP_EN
    m_flip    = '0;
`endif
    for (int i = 0; i < N; i++) begin
      m_sx[i] = 0;
      m_sy[i] = 0;
    end
    pipe_val.delete();
    pipe_ovl.delete();
    repeat (2) begin
      pipe_val.push_back(0);
      pipe_ovl.push_back(1'b0);
    end
  endtask

  task automatic modelStep(input int x, input int y, input logic vs);
    int p, a, val;
    logic own, other, fs_now, ovl_out;
    logic [N*AW-1:0] addrv;
    fs_now = m_prev_vs && !vs;
    val    = 0;
    own    = 1'b0;
    other  = 1'b0;
    addrv  = '0;
    for (int i = 0; i < N; i++) begin
      lookup(i, x, y, p, a);
      addrv[i*AW +: AW] = AW'(a);
      if (p != 0 && val == 0) val = p;
      if (p != 0 && i == 0) own = 1'b1;
      if (p != 0 && i != 0) other = 1'b1;
    end
    pipe_val.push_back(val);
    pipe_ovl.push_back(own && other);
    m_sd    = pipe_val.pop_front();
    ovl_out = pipe_ovl.pop_front();
    if (fs_now) begin
      m_col = m_acc | ovl_out;
      m_acc = 1'b0;
    end else begin
      m_acc = m_acc | ovl_out;
    end
    m_addr = addrv;
    if (fs_now) begin
      m_en = spr_en;
`ifdef SPRITE_FLIP_EN
      m_flip = spr_flip;
`endif
      for (int i = 0; i < N; i++) begin
        m_sx[i] = int'(spr_x[i*10 +: 10]);
        m_sy[i] = int'(spr_y[i*10 +: 10]);
      end
    end
    m_prev_vs = vs;
  endtask

  task automatic applyStimulus(input int x, input int y, input logic vs);
    DrawX  = 10'(x);
    DrawY  = 10'(y);
    VGA_VS = vs;
    @(posedge VGA_CLK);
    if (!Reset_n) modelReset();
    else modelStep(x, y, vs);
    #1;
    checkOutput("sprite_data", {60'd0, sprite_data}, 64'(m_sd));
    checkOutput("collide", {63'd0, collide}, {63'd0, m_col});
    checkOutput("rom_addr", 64'(rom_addr), 64'(m_addr));
  endtask

  task automatic setSprite(input int i, input int x, input int y);
    spr_x[i*10 +: 10] = 10'(x);
    spr_y[i*10 +: 10] = 10'(y);
  endtask

  function automatic int randPos(input int maxv);
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return int'($urandom_range(600, 639));
    if (r == 1) return int'($urandom_range(0, 12));
    if (r == 2) return int'($urandom_range(640, 1023));
    return int'($urandom_range(0, maxv));
  endfunction

  task automatic randomizeSprites();
    int bx, by;
    bx = randPos(639);
    by = randPos(479);
    setSprite(0, bx, by);
    for (int i = 1; i < N; i++) begin
      if ($urandom_range(0, 1) == 1)
        setSprite(i, (bx + int'($urandom_range(0, 40)) - 20) & 1023,
                     (by + int'($urandom_range(0, 40)) - 20) & 1023);
      else
        setSprite(i, randPos(639), randPos(479));
    end
    spr_en    = N'($urandom);
    spr_en[0] = ($urandom_range(0, 3) != 0);
    spr_flip  = N'($urandom);
  endtask

  initial begin
    Reset_n  = 1'b0;
    VGA_VS   = 1'b1;
    DrawX    = '0;
    DrawY    = '0;
    spr_x    = '0;
    spr_y    = '0;
    spr_en   = '0;
    spr_flip = '0;
    modelReset();

    // Single sprite with a solid ROM; reset held while the pixel would hit.
    for (int i = 0; i < N; i++) for (int a = 0; a < W*H; a++) mem[i][a] = 4'd5;
    setSprite(0, 100, 50);
    spr_en = 4'b0001;
    repeat (3) applyStimulus(110, 60, 1'b1);
    Reset_n = 1'b1;
    applyStimulus(0, 0, 1'b1);
    applyStimulus(0, 0, 1'b0);
    applyStimulus(103, 52, 1'b1);
    checkOutput("addr_103_52", 64'(rom_addr[AW-1:0]), 64'd67);
    applyStimulus(300, 52, 1'b1);
    applyStimulus(300, 52, 1'b1);
    checkOutput("single_pix", {60'd0, sprite_data}, 64'd5);
    for (int x = 96; x < 136; x++) applyStimulus(x, 50, 1'b1);
    for (int x = 96; x < 136; x++) applyStimulus(x, 81, 1'b1);
    for (int x = 96; x < 136; x++) applyStimulus(x, 82, 1'b1);

    // Priority, transparency, collision and shadowing.
    Reset_n = 1'b0;
    for (int a = 0; a < W*H; a++) begin
      mem[0][a] = a[0] ? 4'd2 : 4'd0;
      mem[1][a] = 4'd7;
      mem[2][a] = 4'd3;
    end
    setSprite(0, 200, 100);
    setSprite(1, 200, 100);
    setSprite(2, 400, 300);
    spr_en = 4'b0111;
    applyStimulus(0, 0, 1'b1);
    Reset_n = 1'b1;
    applyStimulus(0, 0, 1'b1);
    applyStimulus(0, 0, 1'b0);
    applyStimulus(200, 100, 1'b1);
    applyStimulus(201, 100, 1'b1);
    applyStimulus(0, 0, 1'b1);
    checkOutput("prio_transparent", {60'd0, sprite_data}, 64'd7);
    applyStimulus(0, 0, 1'b1);
    checkOutput("prio_opaque", {60'd0, sprite_data}, 64'd2);
    applyStimulus(0, 0, 1'b1);
    applyStimulus(0, 0, 1'b0);
    checkOutput("collide_set", {63'd0, collide}, 64'd1);
    repeat (3) applyStimulus(400, 300, 1'b1);
    applyStimulus(0, 0, 1'b1);
    applyStimulus(0, 0, 1'b0);
    checkOutput("collide_clear", {63'd0, collide}, 64'd0);
    setSprite(0, 300, 100);
    applyStimulus(201, 100, 1'b1);
    applyStimulus(301, 100, 1'b1);
    applyStimulus(0, 0, 1'b1);
    checkOutput("shadow_old", {60'd0, sprite_data}, 64'd2);
    applyStimulus(0, 0, 1'b0);
    applyStimulus(301, 100, 1'b1);
    applyStimulus(0, 0, 1'b1);
    applyStimulus(0, 0, 1'b1);
    checkOutput("shadow_new", {60'd0, sprite_data}, 64'd2);

    // Right-edge clipping: only DrawX 620..639 may show, nothing wraps to the left edge.
    Reset_n = 1'b0;
    for (int a = 0; a < W*H; a++) mem[0][a] = 4'd9;
    setSprite(0, 620, 10);
    spr_en   = 4'b0001;
    spr_flip = 4'b0001;
    applyStimulus(0, 0, 1'b1);
    Reset_n = 1'b1;
    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 0, 1'b1);
    clip_hits = 0;
    for (int x = 600; x < 660; x++) begin
      applyStimulus(x, 10, 1'b1);
      if (sprite_data != 4'd0) clip_hits++;
    end
    for (int x = 0; x < 16; x++) begin
      applyStimulus(x, 10, 1'b1);
      if (sprite_data != 4'd0) clip_hits++;
    end
    checkOutput("clip_count", 64'(clip_hits), 64'd20);
`ifdef SPRITE_FLIP_EN
    applyStimulus(620, 10, 1'b1);
    checkOutput("flip_addr", 64'(rom_addr[AW-1:0]), 64'd31);
`endif

    // Randomized frames with mid-frame position changes and one mid-frame reset.
    Reset_n = 1'b0;
    for (int i = 0; i < N; i++)
      for (int a = 0; a < W*H; a++)
        mem[i][a] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    applyStimulus(0, 0, 1'b1);
    Reset_n = 1'b1;
    for (int f = 0; f < 40; f++) begin
      randomizeSprites();
      for (int c = 0; c < 120; c++) begin
        int j, x, y;
        if (c == 60) randomizeSprites();
        j = int'($urandom_range(0, N-1));
        x = (m_sx[j] + int'($urandom_range(0, W+7)) - 4) & 1023;
        y = (m_sy[j] + int'($urandom_range(0, H+7)) - 4) & 1023;
        if ($urandom_range(0, 7) == 0) begin
          x = int'($urandom_range(0, 1023));
          y = int'($urandom_range(0, 1023));
        end
        if (f == 20 && c == 50) begin
          Reset_n = 1'b0;
          applyStimulus(x, y, 1'b1);
          applyStimulus(x, y, 1'b1);
          Reset_n = 1'b1;
        end
        applyStimulus(x, y, (c >= 116) ? 1'b0 : 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
